// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter in front of a single-ported data memory.
//   Port 0 : pipeline MEM stage. Owns the memory by default and is never
//            queued. When port 1 takes the memory, port 0 is stalled.
//   Port 1 : debug/DMA master. It raises p1_req and holds it until p1_gnt.
//            Each grant is followed by one turnaround/response cycle, so two
//            port-1 grants are never back to back.
//
// Build option:
//   ARB_STARVE_EN  defined   -> port 1 is forced in after STARVE_LIMIT
//                               consecutive denied cycles.
//                  undefined -> port 0 has strict priority and port 1 only
//                               gets in when port 0 is idle.
//
// Ports:
//   clk, reset              clock and synchronous active-low reset
//   p0_rd/wr/addr/wdata/func3, p0_stall
//                           pipeline request and stall back to the pipeline
//   p1_req/we/addr/wdata/func3, p1_gnt, p1_rvalid, p1_rdata
//                           debug/DMA request, grant and registered read data
//   mem_rd/wr/addr/wdata/func3, mem_rdata
//                           data memory side; mem_rdata is combinational
//                           from mem_addr
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned DM_ADDRESS   = 9,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  p0_rd,
    input  logic                  p0_wr,
    input  logic [DM_ADDRESS-1:0] p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    input  logic [2:0]            p0_func3,
    output logic                  p0_stall,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DM_ADDRESS-1:0] p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    input  logic [2:0]            p1_func3,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p1_rdata,

    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    // Port 0 owns the memory in StIdle and StResp, port 1 only in StGrant1.
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGrant1 = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              p0_busy;
    logic              starve_hit;
    logic              take_p1;
    logic              p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    assign p0_busy = p0_rd | p0_wr;

    // Port 1 is taken from idle when port 0 leaves the memory free, or when
    // port 1 has been denied long enough.
    assign take_p1 = (state_q == StIdle) & p1_req & (~p0_busy | starve_hit);

`ifdef ARB_STARVE_EN
    localparam logic [3:0] LimitCnt = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign starve_hit = (starve_cnt_q == LimitCnt);

    // Counts denied port-1 cycles. Saturates at the limit; holds while port 1
    // is not asking and through the response cycle.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (take_p1) begin
            starve_cnt_d = '0;
        end else if ((state_q == StIdle) && p1_req && p0_busy && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Strict priority: port 1 is never forced in. Legal limits are nonzero,
    // so this is a constant 0.
    assign starve_hit = (STARVE_LIMIT == 0);
`endif

    // One grant cycle, then one response cycle, then back to idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (take_p1) begin
                    state_d = StGrant1;
                end
            end
            StGrant1: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Read data is captured on the edge leaving StGrant1 and held until the
    // next port-1 read, so a write grant leaves p1_rdata untouched.
    always_comb begin
        p1_rvalid_d = (state_q == StGrant1) & ~p1_we;
        p1_rdata_d  = p1_rvalid_d ? mem_rdata : p1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            p1_rvalid_q <= 1'b0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            p1_rvalid_q <= p1_rvalid_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    // Memory-side mux and handshakes. Port-0 requests are forwarded as-is,
    // including the illegal rd+wr combination.
    always_comb begin
        p1_gnt   = (state_q == StGrant1);
        p0_stall = p1_gnt & p0_busy;
        if (p1_gnt) begin
            mem_rd    = ~p1_we;
            mem_wr    = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_func3 = p1_func3;
        end else begin
            mem_rd    = p0_rd;
            mem_wr    = p0_wr;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_func3 = p0_func3;
        end
    end

    assign p1_rvalid = p1_rvalid_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Scoreboard bench for dmem_arbiter. Every stimulus cycle pushes the expected
// outputs of that cycle into a queue and every predicted port-1 read pushes
// its expected data into a response queue; a separate monitor pops and
// compares. The reference model tracks who owns the memory with a small slot
// counter and a denied-cycle count. Follows ARB_STARVE_EN like the design.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_rd, p0_wr;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic [2:0]    p0_func3;
    logic          p0_stall;
    logic          p1_req, p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic [2:0]    p1_func3;
    logic          p1_gnt, p1_rvalid;
    logic [DW-1:0] p1_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_func3;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem_arr [0:(1<<AW)-1];

    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr];

    dmem_arbiter #(
        .DM_ADDRESS  (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .p0_rd    (p0_rd),
        .p0_wr    (p0_wr),
        .p0_addr  (p0_addr),
        .p0_wdata (p0_wdata),
        .p0_func3 (p0_func3),
        .p0_stall (p0_stall),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_addr  (p1_addr),
        .p1_wdata (p1_wdata),
        .p1_func3 (p1_func3),
        .p1_gnt   (p1_gnt),
        .p1_rvalid(p1_rvalid),
        .p1_rdata (p1_rdata),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_func3(mem_func3),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic          gnt;
        logic          stall;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [2:0]    f3;
        logic          rvalid;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          cyc_q[$];
    logic [DW-1:0] resp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    // Reference model: slot 0 = port 0 owns memory, 1 = port-1 access cycle,
    // 2 = response cycle. denied counts port-1 cycles refused while port 0 ran.
    int            slot      = 0;
    bit            slot_read = 1'b0;
    int            denied    = 0;
    logic [DW-1:0] rdata_m   = '0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Called right after the inputs of a cycle are driven: predicts this
    // cycle's outputs, then advances the model across the coming edge.
    task automatic model_cycle(output bit grant_now);
        exp_t e;
        bit   busy;
        bit   starve;
        #1;
        busy      = (p0_rd | p0_wr);
        grant_now = (slot == 1);
        e.gnt     = grant_now;
        e.stall   = grant_now & busy;
        if (grant_now) begin
            e.rd = !p1_we; e.wr = p1_we; e.addr = p1_addr; e.wdata = p1_wdata;
            e.f3 = p1_func3;
        end else begin
            e.rd = p0_rd; e.wr = p0_wr; e.addr = p0_addr; e.wdata = p0_wdata;
            e.f3 = p0_func3;
        end
        e.rvalid = (slot == 2) && slot_read;
        e.rdata  = rdata_m;
        cyc_q.push_back(e);

        if (!reset) begin
            slot = 0; denied = 0; rdata_m = '0; slot_read = 1'b0;
        end else if (slot == 1) begin
            slot_read = !p1_we;
            if (!p1_we) begin
                rdata_m = mem_arr[p1_addr];
                resp_q.push_back(rdata_m);
            end
            slot = 2;
        end else if (slot == 2) begin
            slot = 0;
        end else if (p1_req) begin
            starve = 1'b0;
`ifdef ARB_STARVE_EN
            starve = (denied >= LIMIT);
`endif
            if (!busy || starve) begin
                slot   = 1;
                denied = 0;
            end else if (denied < LIMIT) begin
                denied++;
            end
        end
    endtask

    // Monitor: compares each cycle's outputs and every port-1 read response.
    exp_t          mon_e;
    logic [DW-1:0] mon_r;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (cyc_q.size() > 0) begin
                mon_e = cyc_q.pop_front();
                chk("p1_gnt", p1_gnt, mon_e.gnt);
                chk("p0_stall", p0_stall, mon_e.stall);
                chk("mem_rd", mem_rd, mon_e.rd);
                chk("mem_wr", mem_wr, mon_e.wr);
                chk("mem_addr", mem_addr, mon_e.addr);
                chk("mem_wdata", mem_wdata, mon_e.wdata);
                chk("mem_func3", mem_func3, mon_e.f3);
                chk("p1_rvalid", p1_rvalid, mon_e.rvalid);
                chk("p1_rdata_hold", p1_rdata, mon_e.rdata);
            end
            if (p1_rvalid === 1'b1) begin
                if (resp_q.size() == 0) begin
                    chk("rvalid_unexpected", p1_rvalid, 1'b0);
                end else begin
                    mon_r = resp_q.pop_front();
                    chk("resp_rdata", p1_rdata, mon_r);
                end
            end
        end
    end

    task automatic drive_p0(input bit rd, input bit wr);
        p0_rd    = rd;
        p0_wr    = wr;
        p0_addr  = AW'($urandom);
        p0_wdata = $urandom;
        p0_func3 = 3'($urandom);
    endtask

    task automatic drive_p1(input bit req, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [2:0] f3);
        p1_req   = req;
        p1_we    = we;
        p1_addr  = addr;
        p1_wdata = wdata;
        p1_func3 = f3;
    endtask

    task automatic reset_cycle();
        bit g;
        @(negedge clk);
        reset  = 1'b0;
        p1_req = 1'b0;
        drive_p0(1'b0, 1'b0);
        model_cycle(g);
    endtask

    // Port 0 busy every cycle; port 1 requests (if hold) until granted.
    task automatic busy_run(input int n, input bit hold, output int first,
                            output int stalls, output int gnts);
        bit g;
        bit req;
        bit rd;
        first  = 0;
        stalls = 0;
        gnts   = 0;
        req    = hold;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            reset = 1'b1;
            rd    = ($urandom_range(0, 1) == 1);
            drive_p0(rd, !rd || ($urandom_range(0, 1) == 1));
            p1_req = req;
            model_cycle(g);
            #1;
            if (p1_gnt === 1'b1) begin
                gnts++;
                if (first == 0) first = c;
            end
            if (p0_stall === 1'b1) stalls++;
            if (g) req = 1'b0;
        end
    endtask

    initial begin
        bit   g;
        int   first, stalls, gnts;
        bit   pending;
        int   pbusy;
        bit   rd;

        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = $urandom;
        reset = 1'b0;
        drive_p0(1'b0, 1'b0);
        drive_p1(1'b0, 1'b0, '0, '0, 3'd0);
        repeat (2) @(negedge clk);

        // Idle read by port 1.
        mem_arr[16] = 32'hDEAD_BEEF;
        @(negedge clk);
        reset = 1'b1;
        drive_p0(1'b0, 1'b0);
        drive_p1(1'b1, 1'b0, 9'h010, $urandom, 3'b010);
        model_cycle(g);
        #1;
        chk("rst_rdata", p1_rdata, 32'h0);
        chk("rst_rvalid", p1_rvalid, 1'b0);
        chk("rd_no_gnt_yet", p1_gnt, 1'b0);
        @(negedge clk);
        drive_p0(1'b0, 1'b0);
        model_cycle(g);
        #1;
        chk("rd_gnt", p1_gnt, 1'b1);
        chk("rd_mem_rd", mem_rd, 1'b1);
        chk("rd_mem_addr", mem_addr, 9'h010);
        @(negedge clk);
        p1_req = 1'b0;
        drive_p0(1'b0, 1'b0);
        model_cycle(g);
        #1;
        chk("rd_rvalid", p1_rvalid, 1'b1);
        chk("rd_rdata", p1_rdata, 32'hDEAD_BEEF);
        chk("rd_gnt_gone", p1_gnt, 1'b0);

        // Idle write by port 1.
        @(negedge clk);
        drive_p0(1'b0, 1'b0);
        drive_p1(1'b1, 1'b1, 9'h020, 32'h1234_5678, 3'b010);
        model_cycle(g);
        @(negedge clk);
        drive_p0(1'b0, 1'b0);
        model_cycle(g);
        #1;
        chk("wr_mem_wr", mem_wr, 1'b1);
        chk("wr_mem_rd", mem_rd, 1'b0);
        chk("wr_mem_addr", mem_addr, 9'h020);
        chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        @(negedge clk);
        p1_req = 1'b0;
        drive_p0(1'b0, 1'b0);
        model_cycle(g);
        #1;
        chk("wr_no_rvalid", p1_rvalid, 1'b0);
        chk("wr_rdata_kept", p1_rdata, 32'hDEAD_BEEF);

        // Reset during a port-1 grant abandons the access.
        @(negedge clk);
        drive_p0(1'b0, 1'b0);
        drive_p1(1'b1, 1'b0, AW'($urandom), $urandom, 3'b000);
        model_cycle(g);
        @(negedge clk);
        reset = 1'b0;
        drive_p0(1'b1, 1'b0);
        model_cycle(g);
        #1;
        chk("rg_gnt", p1_gnt, 1'b1);
        chk("rg_stall", p0_stall, 1'b1);
        @(negedge clk);
        reset  = 1'b1;
        p1_req = 1'b0;
        drive_p0(1'b0, 1'b1);
        model_cycle(g);
        #1;
        chk("rg_rvalid", p1_rvalid, 1'b0);
        chk("rg_rdata", p1_rdata, 32'h0);
        chk("rg_gnt_off", p1_gnt, 1'b0);
        chk("rg_mem_wr", mem_wr, p0_wr);
        chk("rg_mem_addr", mem_addr, p0_addr);

        // Port 0 busy every cycle, port 1 held.
        reset_cycle();
        drive_p1(1'b0, 1'b0, 9'h044, $urandom, 3'b010);
        busy_run(20, 1'b1, first, stalls, gnts);
`ifdef ARB_STARVE_EN
        chk("starve_gnt_cycle", first, LIMIT + 2);
        chk("starve_stall_cycles", stalls, 1);
`else
        chk("strict_no_gnt", gnts, 0);
        chk("strict_no_stall", stalls, 0);
`endif

        // One-cycle pulse while busy: dropped, but the denied count survives.
        reset_cycle();
        busy_run(1, 1'b1, first, stalls, gnts);
        chk("pulse_no_gnt", gnts, 0);
        busy_run(3, 1'b0, first, stalls, gnts);
        chk("pulse_idle_no_gnt", gnts, 0);
        busy_run(20, 1'b1, first, stalls, gnts);
`ifdef ARB_STARVE_EN
        chk("pulse_carry_gnt_cycle", first, LIMIT + 1);
`else
        chk("pulse_strict_no_gnt", gnts, 0);
`endif

        // Random traffic with changing port-0 load, drops and rare resets.
        pending = 1'b0;
        pbusy   = 50;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if ((n % 100) == 0) pbusy = $urandom_range(0, 100);
            reset = ($urandom_range(0, 199) != 0);
            rd    = ($urandom_range(0, 99) < pbusy);
            drive_p0(rd, ($urandom_range(0, 99) < pbusy / 2));
            if (!pending) begin
                if ($urandom_range(0, 3) == 0) begin
                    pending = 1'b1;
                    drive_p1(1'b1, ($urandom_range(0, 1) == 1), AW'($urandom), $urandom,
                             3'($urandom));
                end
            end else if ($urandom_range(0, 31) == 0) begin
                pending = 1'b0;
            end
            p1_req = pending;
            if ($urandom_range(0, 7) == 0) mem_arr[$urandom_range(0, (1 << AW) - 1)] = $urandom;
            model_cycle(g);
            if (g) pending = 1'b0;
        end

        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            reset  = 1'b1;
            p1_req = 1'b0;
            drive_p0(1'b0, 1'b0);
            model_cycle(g);
        end
        @(negedge clk);
        #3;
        chk("resp_queue_drained", resp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
